// File: rtl/core_pkg.sv
// core_pkg: shared issue-stage types and widths
package core_pkg;
    localparam int INSTR_W = 64;
    typedef enum logic {RUN, BR_WAIT} issue_state_e;
endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: registered synchronous FIFO with push/pop/clear and occupancy count
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            wr_ptr  <= i_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr  <= i_pop ? rd_ptr + AW'(1) : rd_ptr;
            o_count <= o_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_din;
    end
    assign o_dout = mem[rd_ptr];
endmodule

// File: rtl/issue_sched.sv
// issue_sched: in-order issue scheduler allowing one branch in flight
// Optional perf counters o_issue_cnt/o_stall_cnt under `ISSUE_PERF_CNT_EN.
module issue_sched
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int INSTR_W = core_pkg::INSTR_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_fetch_valid,
    output logic                       o_fetch_ready,
    input  logic [INSTR_W-1:0]         i_fetch_instr,
    output logic                       o_id_en,
    output logic [INSTR_W-1:0]         o_id_instr,
    input  logic                       i_id_bru_en,
    input  logic                       i_exec_ready,
    input  logic                       i_bru_done,
    input  logic                       i_flush,
    output logic                       o_br_pending,
    output logic [$clog2(DEPTH+1)-1:0] o_q_count
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]                o_issue_cnt,
    output logic [31:0]                o_stall_cnt
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    issue_state_e state_q, state_d;
    logic push, fire;
    logic [INSTR_W-1:0] head;
    assign o_fetch_ready = !i_rst && !i_flush && (o_q_count < CW'(DEPTH));
    assign push = i_fetch_valid && o_fetch_ready;
    assign o_id_en = (o_q_count != '0) && (state_q == RUN);
    assign fire = o_id_en && i_exec_ready;
    assign o_id_instr = o_id_en ? head : '0;
    assign o_br_pending = (state_q == BR_WAIT);
    issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_flush),
        .i_push  (push),
        .i_pop   (fire),
        .i_din   (i_fetch_instr),
        .o_dout  (head),
        .o_count (o_q_count)
    );
    always_comb begin
        state_d = state_q;
        if (i_flush) state_d = RUN;
        else if (state_q == RUN && fire && i_id_bru_en) state_d = BR_WAIT;
        else if (state_q == BR_WAIT && i_bru_done) state_d = RUN;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= RUN;
        else state_q <= state_d;
    end
`ifdef ISSUE_PERF_CNT_EN
    // counters survive flush; only reset clears them
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_issue_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            o_issue_cnt <= fire ? o_issue_cnt + 32'd1 : o_issue_cnt;
            o_stall_cnt <= (o_q_count != '0 && !fire) ? o_stall_cnt + 32'd1 : o_stall_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed self-checking bench for issue_sched
module tb_issue_sched;
    logic        clk = 0;
    logic        rst = 1;
    logic        fetch_valid = 0;
    logic        fetch_ready;
    logic [63:0] fetch_instr = '0;
    logic        id_en;
    logic [63:0] id_instr;
    logic        bru_en = 0;
    logic        exec_ready = 0;
    logic        bru_done = 0;
    logic        flush = 0;
    logic        br_pending;
    logic [2:0]  q_count;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] issue_cnt, stall_cnt, issue0, stall0;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] w [5];
    logic [63:0] s [10];

    always #5 clk = ~clk;

    issue_sched dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fetch_valid (fetch_valid),
        .o_fetch_ready (fetch_ready),
        .i_fetch_instr (fetch_instr),
        .o_id_en       (id_en),
        .o_id_instr    (id_instr),
        .i_id_bru_en   (bru_en),
        .i_exec_ready  (exec_ready),
        .i_bru_done    (bru_done),
        .i_flush       (flush),
        .o_br_pending  (br_pending),
        .o_q_count     (q_count)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .o_issue_cnt   (issue_cnt),
        .o_stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else pass_cnt++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        w[0] = 64'h1111_0000_0000_0001; w[1] = 64'h2222_0000_0000_0002;
        w[2] = 64'h3333_0000_0000_0003; w[3] = 64'h4444_0000_0000_0004;
        w[4] = 64'h5555_0000_0000_0005;
        for (int i = 0; i < 10; i++) s[i] = 64'hA000_0000_0000_0000 | 64'(i * 17 + 3);
        tick;
        #1 check("rst_fetch_ready", fetch_ready, 0);
        tick;
        rst = 0;
        #1;
        check("post_rst_ready", fetch_ready, 1);
        check("post_rst_count", q_count, 0);
        check("post_rst_id_en", id_en, 0);
        check("post_rst_instr", id_instr, 0);
        check("post_rst_brp", br_pending, 0);
        // 1: branch issue
        fetch_valid = 1; fetch_instr = 64'h48032BFB_00000000; bru_en = 1; exec_ready = 1;
        tick;
        fetch_valid = 0;
        #1;
        check("br_id_en", id_en, 1);
        check("br_instr", id_instr, 64'h48032BFB_00000000);
        tick;
        check("br_pending", br_pending, 1);
        check("br_id_en_off", id_en, 0);
        check("br_count0", q_count, 0);
        // 2: push during BR_WAIT, release by bru_done
        bru_en = 0; fetch_valid = 1; fetch_instr = 64'h38210010_00000000;
        tick;
        fetch_valid = 0;
        #1;
        check("wait_id_en", id_en, 0);
        check("wait_count", q_count, 1);
        tick;
        check("wait_id_en2", id_en, 0);
        check("wait_count2", q_count, 1);
        bru_done = 1;
        #1 check("done_cycle_id_en", id_en, 0);
        tick;
        bru_done = 0;
        #1;
        check("resume_brp", br_pending, 0);
        check("resume_id_en", id_en, 1);
        check("resume_instr", id_instr, 64'h38210010_00000000);
        tick;
        check("resume_count0", q_count, 0);
        // 3/6: fill with exec held off
        exec_ready = 0;
`ifdef ISSUE_PERF_CNT_EN
        issue0 = issue_cnt; stall0 = stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            fetch_valid = 1; fetch_instr = w[i];
            #1;
            if (i == 4) check("full_ready", fetch_ready, 0);
            tick;
        end
        fetch_valid = 0;
        #1;
        check("full_count", q_count, 4);
        check("full_head", id_instr, w[0]);
        check("full_id_en", id_en, 1);
        tick;
        exec_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("drain_%0d", i), id_instr, w[i]);
            tick;
        end
        check("drain_count0", q_count, 0);
        check("drain_id_en0", id_en, 0);
`ifdef ISSUE_PERF_CNT_EN
        check("perf_issue", 64'(issue_cnt - issue0), 4);
        check("perf_stall", 64'(stall_cnt - stall0), 5);
`endif
        // 4: flush with count=3 in BR_WAIT, plus bru_done and push same cycle
        fetch_valid = 1; fetch_instr = 64'h48000000_00000000; bru_en = 1;
        tick;
        fetch_valid = 0;
        tick;
        bru_en = 0;
        check("fl_brp", br_pending, 1);
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1; fetch_instr = w[i];
            tick;
        end
        fetch_valid = 1;
        #1;
        check("fl_pre_count", q_count, 3);
        check("fl_pre_id_en", id_en, 0);
        flush = 1; bru_done = 1; fetch_instr = w[4];
        #1 check("fl_ready", fetch_ready, 0);
        tick;
        flush = 0; bru_done = 0; fetch_valid = 0;
        #1;
        check("fl_count", q_count, 0);
        check("fl_brp_clr", br_pending, 0);
        check("fl_id_en", id_en, 0);
        // 5: stream 10 words, one issue per cycle with wrap
        for (int k = 0; k <= 10; k++) begin
            fetch_valid = (k < 10); fetch_instr = (k < 10) ? s[k % 10] : '0;
            #1;
            if (k > 0) begin
                check($sformatf("st_en_%0d", k), id_en, 1);
                check($sformatf("st_instr_%0d", k), id_instr, s[k-1]);
                check($sformatf("st_count_%0d", k), q_count, 1);
            end
            tick;
        end
        check("st_count_end", q_count, 0);
        // reset mid-operation overrides everything
        exec_ready = 0; fetch_valid = 1; fetch_instr = w[0];
        tick; tick;
        check("mid_count", q_count, 2);
        rst = 1; flush = 1;
        tick;
        rst = 0; flush = 0; fetch_valid = 0;
        #1;
        check("mid_rst_count", q_count, 0);
        check("mid_rst_id_en", id_en, 0);
        check("mid_rst_ready", fetch_ready, 1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
